// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - registered ALU execute stage with valid/ready handshakes; optional iterative shifter under ALU_SHIFT_EN
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
`ifdef ALU_SHIFT_EN
  localparam logic [1:0] SHIFT = 2'd2;
`endif

  logic [1:0]       state;
  logic             run;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
`ifdef ALU_SHIFT_EN
  logic             is_shift;
  logic [WIDTH-1:0] work;
  logic [4:0]       cnt;
  logic [1:0]       mode;
  logic [WIDTH-1:0] shift_next;
`endif

  assign sum       = op_a + op_b;
  assign diff      = op_a - op_b;
  assign out_valid = (state == FULL);
  // run gates in_ready so it stays low in reset and rises on the first clock afterwards
  assign in_ready  = run && ((state == EMPTY) || ((state == FULL) && out_ready));
  assign accept    = in_valid && in_ready;

  // single-cycle datapath; unknown codes yield zero so the stage never stalls on them
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
`ifdef ALU_SHIFT_EN
    is_shift = 1'b0;
`endif
    case (alu_ctl)
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      4'b0010: begin
        alu_res = sum;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'b0110: begin
        alu_res = diff;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef ALU_SHIFT_EN
      // shift by zero completes immediately with op_a unchanged
      4'b1000, 4'b1001, 4'b1010: begin
        alu_res  = op_a;
        is_shift = 1'b1;
      end
`endif
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SHIFT_EN
  // one-bit shift step; mode holds alu_ctl[1:0] (00 SLL, 01 SRL, 10 SRA)
  always_comb begin
    shift_next = work;
    case (mode)
      2'b00:   shift_next = {work[WIDTH-2:0], 1'b0};
      2'b01:   shift_next = {1'b0, work[WIDTH-1:1]};
      default: shift_next = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end
`endif

  // handshake state, result registers and iterative shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      run    <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
`ifdef ALU_SHIFT_EN
      work   <= '0;
      cnt    <= '0;
      mode   <= 2'b00;
`endif
    end else begin
      run <= 1'b1;
      if (accept) begin
`ifdef ALU_SHIFT_EN
        if (is_shift && (op_b[4:0] != 5'd0)) begin
          work  <= op_a;
          cnt   <= op_b[4:0];
          mode  <= alu_ctl[1:0];
          state <= SHIFT;
        end else
`endif
        begin
          result <= alu_res;
          zero   <= (alu_res == '0);
          ovf    <= alu_ovf;
          state  <= FULL;
        end
      end else if ((state == FULL) && out_ready) begin
        state <= EMPTY;
      end
`ifdef ALU_SHIFT_EN
      else if (state == SHIFT) begin
        work <= shift_next;
        cnt  <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          result <= shift_next;
          zero   <= (shift_next == '0);
          ovf    <= 1'b0;
          state  <= FULL;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed table-driven bench for alu_exec
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctl = 4'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        ovf;

  int total = 0;
  int bad = 0;
  logic        mon_en = 1'b0;
  logic [31:0] got_q[$];

  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_exec #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctl(alu_ctl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mon_en && out_valid && out_ready) got_q.push_back(result);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic z, output logic o,
                       output int lat, output int busy);
    int guard;
    @(negedge clk);
    alu_ctl = c; op_a = a; op_b = b; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; op_a = 32'hdeadbeef; op_b = 32'hffffffff;
    lat = 1; busy = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy++;
      @(posedge clk);
      #1;
      lat++;
    end
    r = result; z = zero; o = ovf;
  endtask

  initial begin
    logic [31:0] r;
    logic z, o;
    int lat, busy, k;

    vecs.push_back('{"add_ovf",   4'b0010, 32'h7fffffff, 32'h1,        32'h80000000, 1'b0, 1'b1, 1});
    vecs.push_back('{"sub_zero",  4'b0110, 32'd5,        32'd5,        32'h0,        1'b1, 1'b0, 1});
    vecs.push_back('{"slt_neg",   4'b0111, 32'hffffffff, 32'h1,        32'h1,        1'b0, 1'b0, 1});
    vecs.push_back('{"and",       4'b0000, 32'hf0f0,     32'hff00,     32'hf000,     1'b0, 1'b0, 1});
    vecs.push_back('{"or",        4'b0001, 32'hf0f0,     32'hff00,     32'hfff0,     1'b0, 1'b0, 1});
    vecs.push_back('{"sub_ovf",   4'b0110, 32'h80000000, 32'h1,        32'h7fffffff, 1'b0, 1'b1, 1});
    vecs.push_back('{"add_wrap",  4'b0010, 32'hffffffff, 32'h1,        32'h0,        1'b1, 1'b0, 1});
    vecs.push_back('{"slt_pos",   4'b0111, 32'h1,        32'hffffffff, 32'h0,        1'b1, 1'b0, 1});
    vecs.push_back('{"add_negov", 4'b0010, 32'h80000000, 32'h80000000, 32'h0,        1'b1, 1'b1, 1});
    vecs.push_back('{"sub_ovf2",  4'b0110, 32'h0,        32'h80000000, 32'h80000000, 1'b0, 1'b1, 1});
    vecs.push_back('{"illegal",   4'b1111, 32'd5,        32'd3,        32'h0,        1'b1, 1'b0, 1});
`ifdef ALU_SHIFT_EN
    vecs.push_back('{"sra4",      4'b1010, 32'h80000000, 32'd4,        32'hf8000000, 1'b0, 1'b0, 5});
    vecs.push_back('{"sll31",     4'b1000, 32'h1,        32'd31,       32'h80000000, 1'b0, 1'b0, 32});
    vecs.push_back('{"srl0",      4'b1001, 32'h12345678, 32'h20,       32'h12345678, 1'b0, 1'b0, 1});
    vecs.push_back('{"srl4",      4'b1001, 32'hf0000000, 32'd4,        32'h0f000000, 1'b0, 1'b0, 5});
`else
    vecs.push_back('{"sll_off",   4'b1000, 32'd5,        32'd3,        32'h0,        1'b1, 1'b0, 1});
    vecs.push_back('{"sra_off",   4'b1010, 32'h80000000, 32'd4,        32'h0,        1'b1, 1'b0, 1});
`endif

    // reset state
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd0);
    check("rst_result",    result,             32'd0);
    check("rst_zero",      {31'b0, zero},      32'd0);
    check("rst_ovf",       {31'b0, ovf},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // table of single transactions
    foreach (vecs[i]) begin
      do_op(vecs[i].ctl, vecs[i].a, vecs[i].b, r, z, o, lat, busy);
      check({vecs[i].name, "_res"}, r, vecs[i].res);
      check({vecs[i].name, "_zero"}, {31'b0, z}, {31'b0, vecs[i].z});
      check({vecs[i].name, "_ovf"}, {31'b0, o}, {31'b0, vecs[i].o});
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      check({vecs[i].name, "_busy_ready"}, busy, 32'd0);
    end

    // back-pressure: four back-to-back ADDs, out_ready low in cycles 2..4
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got_q.delete();
    mon_en = 1'b1;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      logic acc;
      if (c > 1) @(negedge clk);
      out_ready = !(c >= 2 && c <= 4);
      if (k < 4) begin
        in_valid = 1'b1; alu_ctl = 4'b0010; op_a = k; op_b = 32'd100;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 2 && c <= 4) begin
        check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        check("bp_hold_result", result, 32'd100);
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) k++;
      if (k == 4 && got_q.size() == 4) break;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    mon_en = 1'b0;
    check("bp_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check("bp_order", got_q[i], 32'd100 + i);
      else check("bp_missing", 32'hffffffff, 32'd100 + i);
    end

    // reset while an operation is in flight
    @(negedge clk);
`ifdef ALU_SHIFT_EN
    alu_ctl = 4'b1000; op_a = 32'h1; op_b = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    check("mid_shift_valid", {31'b0, out_valid}, 32'd0);
`else
    out_ready = 1'b0;
    alu_ctl = 4'b0010; op_a = 32'd7; op_b = 32'd8; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mid_full_valid", {31'b0, out_valid}, 32'd1);
    #2;
`endif
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_result",    result,             32'd0);
    check("midrst_in_ready",  {31'b0, in_ready},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    do_op(4'b0010, 32'd2, 32'd3, r, z, o, lat, busy);
    check("after_rst_add", r, 32'd5);
    check("after_rst_lat", lat, 32'd1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
